signed_cast_rnd: RTL and testbench
==================================

SIGNED_CAST_RND -- requirements
Module: signed_cast_rnd

Interface
REQ-001 The block SHALL have parameter DIN_WIDTH, default 8, input word width per channel (two's complement).
REQ-002 The block SHALL have parameter DIN_POINT, default 4, input fractional bits.
REQ-003 The block SHALL have parameter DOUT_WIDTH, default 6, output word width per channel.
REQ-004 The block SHALL have parameter DOUT_POINT, default 2, output fractional bits.
REQ-005 The block SHALL have parameter PARALLEL, default 4, number of channels packed side by side, with channel 0 in the LSBs.
REQ-006 The block SHALL have parameter ROUND_MODE, default 1, where 0 = truncate, 1 = round-half-up, 2 = convergent (round-half-even).
REQ-007 The block SHALL have parameter SYMMETRIC, default 0, where 1 clamps the negative limit to -(2^(DOUT_WIDTH-1)-1).
REQ-008 The block SHALL have parameter CNT_WIDTH, default 16, saturation-counter width.
REQ-009 The block SHALL have port clk, input, 1 bit, sole clock, with all logic on its rising edge.
REQ-010 The block SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-011 The block SHALL have port din, input, PARALLEL*DIN_WIDTH bits, packed input samples.
REQ-012 The block SHALL have port din_valid, input, 1 bit, qualifying din.
REQ-013 The block SHALL have port cnt_clr, input, 1 bit, synchronous clear of sat_count.
REQ-014 The block SHALL have port dout, output, PARALLEL*DOUT_WIDTH bits, packed cast samples.
REQ-015 The block SHALL have port dout_valid, output, 1 bit, qualifying dout.
REQ-016 The block SHALL have port ovf, output, PARALLEL bits, per-channel saturation flag aligned with dout.
REQ-017 The block SHALL have port ovf_sticky, output, 1 bit, latched OR of all ovf bits since reset or cnt_clr.
REQ-018 The block SHALL have port sat_count, output, CNT_WIDTH bits, count of valid output cycles with any ovf bit set.

Function
REQ-019 Latency SHALL be exactly 2 clk cycles from din/din_valid to dout/dout_valid/ovf, with one sample accepted every cycle and no backpressure.
REQ-020 Stage 1 SHALL compute, per channel, a sign-extended (DIN_WIDTH+1)-bit value.
REQ-021 When DOUT_POINT >= DIN_POINT, stage 1 SHALL shift left by DOUT_POINT-DIN_POINT (exact, zero fill), and ROUND_MODE SHALL have no effect.
REQ-022 When DOUT_POINT < DIN_POINT, with D = DIN_POINT-DOUT_POINT, stage 1 SHALL add a rounding constant of 0 for mode 0, 2^(D-1) for mode 1, and 2^(D-1)-1+din[D] for mode 2 (din[D] = kept LSB), then arithmetic-shift right by D.
REQ-023 Stage 2 SHALL compare the stage-1 result against MAX = 2^(DOUT_WIDTH-1)-1 and MIN = -2^(DOUT_WIDTH-1), or MIN = -MAX when SYMMETRIC=1.
REQ-024 When the stage-2 result exceeds MAX or MIN, the output SHALL clamp to the limit and set that channel's ovf bit; otherwise the output SHALL be the low DOUT_WIDTH bits and ovf SHALL be 0.
REQ-025 Saturation SHALL apply symmetrically to integer-part overflow and rounding-induced overflow; there SHALL be no wrap-around in any mode.
REQ-026 ovf and ovf_sticky updates SHALL be gated by valid, so samples with valid low never set flags or count.
REQ-027 sat_count SHALL increment by 1 per dout_valid cycle with |ovf, SHALL hold at all-ones (no wrap), and SHALL never count more than 1 per cycle regardless of how many channels overflow.
REQ-028 When cnt_clr coincides with an increment, cnt_clr SHALL win: sat_count = 0 and ovf_sticky = 0 on the next cycle.
REQ-029 When dout_valid is 0, dout and ovf SHALL hold their previous values.

Reset
REQ-030 On rst high at a clk edge, dout, ovf, dout_valid, ovf_sticky, sat_count and both pipeline valid stages SHALL go to 0.
REQ-031 Samples in flight when reset is asserted SHALL be discarded, with no dout_valid pulse for them after rst deasserts.
REQ-032 rst SHALL take priority over din_valid and cnt_clr.
REQ-033 The first sample accepted in the cycle rst deasserts SHALL appear 2 cycles later.

Verification (defaults, 8.4 -> 6.2, channel 0)
REQ-034 The bench SHALL check rounding: din=0x0A (0.625) with mode 0 -> 0x02; mode 1 -> 0x03; mode 2 -> 0x02, with ovf=0.
REQ-035 The bench SHALL check convergent tie: din=0x0E (0.875) with mode 2 -> 0x04 (1.0, even), ovf=0.
REQ-036 The bench SHALL check rounding overflow: din=0x7F with mode 1 -> 0x1F, ovf[0]=1, sat_count=1, ovf_sticky=1.
REQ-037 The bench SHALL check the negative limit: din=0x80 with SYMMETRIC=0 -> 0x20, ovf=0; with SYMMETRIC=1 -> 0x21, ovf[0]=1.
REQ-038 The bench SHALL check multi-channel counting: all 4 channels = 0x7F for 3 valid cycles -> ovf=4'hF, sat_count=3; then cnt_clr together with another overflow -> sat_count=0.
REQ-039 The bench SHALL check reset mid-stream: continuous valid data, rst high 1 cycle -> no dout_valid for 2 cycles after rst; then the next sample appears at latency 2.

Source files
------------

// File: rtl/signed_cast_rnd.sv
// Fixed-point recast of PARALLEL packed two's-complement channels, with
// selectable rounding, saturation, per-channel overflow flags and a saturation counter.
module signed_cast_rnd #(
    parameter int DIN_WIDTH  = 8,
    parameter int DIN_POINT  = 4,
    parameter int DOUT_WIDTH = 6,
    parameter int DOUT_POINT = 2,
    parameter int PARALLEL   = 4,
    parameter int ROUND_MODE = 1,
    parameter int SYMMETRIC  = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PARALLEL*DIN_WIDTH-1:0]    din,
    input  logic                             din_valid,
    input  logic                             cnt_clr,
    output logic [PARALLEL*DOUT_WIDTH-1:0]   dout,
    output logic                             dout_valid,
    output logic [PARALLEL-1:0]              ovf,
    output logic                             ovf_sticky,
    output logic [CNT_WIDTH-1:0]             sat_count
);

    localparam int D    = DIN_POINT - DOUT_POINT;
    localparam int SH_L = (D < 0) ? -D : 0;
    localparam int SH_R = (D > 0) ? D : 0;
    // Stage-1 word grows by the left shift so an up-scaling cast cannot wrap.
    localparam int S1W  = DIN_WIDTH + 1 + SH_L;
    localparam int CW   = ((S1W > DOUT_WIDTH) ? S1W : DOUT_WIDTH) + 1;

    localparam logic signed [CW-1:0] MAX_V = CW'((1 << (DOUT_WIDTH - 1)) - 1);
    localparam logic signed [CW-1:0] MIN_V = (SYMMETRIC != 0) ? -MAX_V : -MAX_V - CW'(1);

    logic signed [S1W-1:0]           s1_val_next [PARALLEL];
    logic signed [S1W-1:0]           s1_val_reg  [PARALLEL];
    logic                            s1_valid_reg;

    logic [PARALLEL*DOUT_WIDTH-1:0]  cast_next;
    logic [PARALLEL-1:0]             ovf_next;
    logic [PARALLEL*DOUT_WIDTH-1:0]  dout_reg;
    logic [PARALLEL-1:0]             ovf_reg;
    logic                            dout_valid_reg;
    logic                            ovf_sticky_reg;
    logic [CNT_WIDTH-1:0]            sat_count_reg;
    logic                            any_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < PARALLEL; gi++) begin : g_ch
            logic signed [DIN_WIDTH-1:0] x;
            logic signed [S1W-1:0]       ext;
            logic signed [CW-1:0]        wide;
            logic                        sat_hi;
            logic                        sat_lo;

            assign x   = din[gi*DIN_WIDTH +: DIN_WIDTH];
            assign ext = S1W'(x);

            if (D > 0) begin : g_rnd
                localparam logic signed [S1W-1:0] HALF = S1W'(1 << (SH_R - 1));
                logic signed [S1W-1:0] rnd;

                // Mode 2 adds one less than half unless the kept LSB is odd,
                // so exact ties move toward the even neighbour.
                always_comb begin
                    rnd = '0;
                    case (ROUND_MODE)
                        1:       rnd = HALF;
                        2:       rnd = HALF - S1W'(1) + S1W'($signed({1'b0, x[SH_R]}));
                        default: rnd = '0;
                    endcase
                end

                assign s1_val_next[gi] = (ext + rnd) >>> SH_R;
            end else begin : g_shl
                assign s1_val_next[gi] = ext <<< SH_L;
            end

            assign wide   = CW'(s1_val_reg[gi]);
            assign sat_hi = (wide > MAX_V);
            assign sat_lo = (wide < MIN_V);

            assign ovf_next[gi] = sat_hi | sat_lo;
            assign cast_next[gi*DOUT_WIDTH +: DOUT_WIDTH] =
                sat_hi ? MAX_V[DOUT_WIDTH-1:0] :
                sat_lo ? MIN_V[DOUT_WIDTH-1:0] :
                         wide[DOUT_WIDTH-1:0];
        end
    endgenerate

    assign any_ovf = s1_valid_reg & (|ovf_next);

    always_ff @(posedge clk) begin
        s1_val_reg <= s1_val_next;
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            dout_valid_reg <= 1'b0;
            dout_reg       <= '0;
            ovf_reg        <= '0;
            ovf_sticky_reg <= 1'b0;
            sat_count_reg  <= '0;
        end else begin
            s1_valid_reg   <= din_valid;
            dout_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                dout_reg <= cast_next;
                ovf_reg  <= ovf_next;
            end
            // Clear wins over a coincident overflow; the counter sticks at all-ones.
            if (cnt_clr) begin
                ovf_sticky_reg <= 1'b0;
                sat_count_reg  <= '0;
            end else if (any_ovf) begin
                ovf_sticky_reg <= 1'b1;
                if (sat_count_reg != {CNT_WIDTH{1'b1}})
                    sat_count_reg <= sat_count_reg + 1'b1;
            end
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign ovf        = ovf_reg;
    assign ovf_sticky = ovf_sticky_reg;
    assign sat_count  = sat_count_reg;

endmodule

// File: tb/tb_signed_cast_rnd.sv
// Bench for signed_cast_rnd: four instances (truncate, half-up, half-even,
// symmetric half-up) share stimulus and are compared each cycle to an arithmetic model.
module tb_signed_cast_rnd;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_valid;
    logic        cnt_clr;
    logic [31:0] din;

    logic [23:0] dout_w [4];
    logic        dv_w   [4];
    logic [3:0]  ovf_w  [4];
    logic        st_w   [4];
    logic [15:0] cnt_w  [4];

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    logic [23:0] e_dout [4];
    logic [3:0]  e_ovf  [4];
    bit          e_st   [4];
    int          e_cnt  [4];
    bit          p_valid = 1'b0;
    bit          p_rst   = 1'b1;
    logic [31:0] p_din   = '0;

    always #5 clk = ~clk;

    signed_cast_rnd #(.ROUND_MODE(0), .SYMMETRIC(0)) u_m0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .dout(dout_w[0]), .dout_valid(dv_w[0]), .ovf(ovf_w[0]),
        .ovf_sticky(st_w[0]), .sat_count(cnt_w[0]));
    signed_cast_rnd #(.ROUND_MODE(1), .SYMMETRIC(0)) u_m1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .dout(dout_w[1]), .dout_valid(dv_w[1]), .ovf(ovf_w[1]),
        .ovf_sticky(st_w[1]), .sat_count(cnt_w[1]));
    signed_cast_rnd #(.ROUND_MODE(2), .SYMMETRIC(0)) u_m2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .dout(dout_w[2]), .dout_valid(dv_w[2]), .ovf(ovf_w[2]),
        .ovf_sticky(st_w[2]), .sat_count(cnt_w[2]));
    signed_cast_rnd #(.ROUND_MODE(1), .SYMMETRIC(1)) u_s1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .dout(dout_w[3]), .dout_valid(dv_w[3]), .ovf(ovf_w[3]),
        .ovf_sticky(st_w[3]), .sat_count(cnt_w[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int mode_of(input int i);
        return (i == 0) ? 0 : (i == 2) ? 2 : 1;
    endfunction

    // 8.4 -> 6.2 by plain integer arithmetic: q = floor(v/4), r = remainder.
    function automatic logic [6:0] ref_cast(input logic [7:0] x, input int mode, input bit sym);
        int v, q, r, lo;
        v  = int'($signed(x));
        q  = (v >= 0) ? v / 4 : -((-v + 3) / 4);
        r  = v - 4 * q;
        if (mode == 1 && r >= 2) q++;
        else if (mode == 2 && (r > 2 || (r == 2 && (q % 2) != 0))) q++;
        lo = sym ? -31 : -32;
        if (q > 31) return {1'b1, 6'h1F};
        if (q < lo) return {1'b1, 6'(lo)};
        return {1'b0, 6'(q)};
    endfunction

    task automatic step(input logic r, input logic v, input logic c, input logic [31:0] d);
        bit         dv;
        bit         any;
        logic [6:0] res;
        rst = r; din_valid = v; cnt_clr = c; din = d;
        @(posedge clk);
        #1;
        dv = p_valid && !p_rst && !r;
        for (int i = 0; i < 4; i++) begin
            any = 1'b0;
            if (r) begin
                e_dout[i] = '0; e_ovf[i] = '0; e_st[i] = 1'b0; e_cnt[i] = 0;
            end else begin
                if (dv) begin
                    for (int ch = 0; ch < 4; ch++) begin
                        res = ref_cast(p_din[8*ch +: 8], mode_of(i), (i == 3));
                        e_dout[i][6*ch +: 6] = res[5:0];
                        e_ovf[i][ch]         = res[6];
                    end
                    any = |e_ovf[i];
                end
                if (c) begin
                    e_st[i] = 1'b0; e_cnt[i] = 0;
                end else if (any) begin
                    e_st[i] = 1'b1;
                    if (e_cnt[i] < 65535) e_cnt[i]++;
                end
            end
            check($sformatf("u%0d.dout_valid", i), 32'(dv_w[i]), 32'(dv));
            check($sformatf("u%0d.dout", i), 32'(dout_w[i]), 32'(e_dout[i]));
            check($sformatf("u%0d.ovf", i), 32'(ovf_w[i]), 32'(e_ovf[i]));
            check($sformatf("u%0d.ovf_sticky", i), 32'(st_w[i]), 32'(e_st[i]));
            check($sformatf("u%0d.sat_count", i), 32'(cnt_w[i]), 32'(e_cnt[i]));
        end
        p_valid = v; p_rst = r; p_din = d;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [7:0]  b;
        for (int ch = 0; ch < 4; ch++) begin
            b = 8'($urandom);
            case ($urandom_range(3))
                0:       b = ($urandom_range(1) == 0) ? 8'h7F : 8'h80;
                1:       b = {b[7:2], 2'b10};
                default: ;
            endcase
            w[8*ch +: 8] = b;
        end
        return w;
    endfunction

    initial begin
        logic [31:0] d1;
        logic [6:0]  r1;

        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
        check("reset_dout_valid", 32'(dv_w[1]), 32'h0);
        check("reset_sat_count", 32'(cnt_w[1]), 32'h0);

        // rounding of 0.625 in each mode
        step(1'b0, 1'b1, 1'b0, 32'h0000000A);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("trunc_0A", 32'(dout_w[0][5:0]), 32'h02);
        check("halfup_0A", 32'(dout_w[1][5:0]), 32'h03);
        check("halfeven_0A", 32'(dout_w[2][5:0]), 32'h02);
        check("ovf_0A", 32'(ovf_w[1]), 32'h0);

        // convergent tie at 0.875
        step(1'b0, 1'b1, 1'b0, 32'h0000000E);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("halfeven_0E", 32'(dout_w[2][5:0]), 32'h04);
        check("halfeven_0E_ovf", 32'(ovf_w[2]), 32'h0);

        // negative limit, plain and symmetric
        step(1'b0, 1'b1, 1'b0, 32'h00000080);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("neg_80", 32'(dout_w[1][5:0]), 32'h20);
        check("neg_80_ovf", 32'(ovf_w[1]), 32'h0);
        check("sym_80", 32'(dout_w[3][5:0]), 32'h21);
        check("sym_80_ovf", 32'(ovf_w[3][0]), 32'h1);

        // rounding-induced overflow
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0000007F);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("rndovf_7F", 32'(dout_w[1][5:0]), 32'h1F);
        check("rndovf_ovf0", 32'(ovf_w[1][0]), 32'h1);
        check("rndovf_cnt", 32'(cnt_w[1]), 32'h1);
        check("rndovf_sticky", 32'(st_w[1]), 32'h1);

        // multi-channel: one count per cycle, then clear beats an overflow
        step(1'b0, 1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 32'h7F7F7F7F);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("multi_ovf", 32'(ovf_w[1]), 32'hF);
        check("multi_cnt", 32'(cnt_w[1]), 32'h3);
        step(1'b0, 1'b1, 1'b0, 32'h7F7F7F7F);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("clr_wins_ovf", 32'(ovf_w[1]), 32'hF);
        check("clr_wins_cnt", 32'(cnt_w[1]), 32'h0);
        check("clr_wins_sticky", 32'(st_w[1]), 32'h0);

        // reset in the middle of a continuous stream
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, rand_word());
        step(1'b1, 1'b1, 1'b0, rand_word());
        check("midrst_dv0", 32'(dv_w[1]), 32'h0);
        d1 = rand_word();
        step(1'b0, 1'b1, 1'b0, d1);
        check("midrst_dv1", 32'(dv_w[1]), 32'h0);
        step(1'b0, 1'b1, 1'b0, rand_word());
        r1 = ref_cast(d1[7:0], 1, 1'b0);
        check("midrst_dv2", 32'(dv_w[1]), 32'h1);
        check("midrst_first", 32'(dout_w[1][5:0]), 32'(r1[5:0]));

        // randomized traffic
        for (int k = 0; k < 400; k++)
            step(($urandom_range(63) == 0), ($urandom_range(3) != 0),
                 ($urandom_range(15) == 0), rand_word());
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
